// File: rtl/uart_rx_param_if.sv
// Receive-side bundle of the parametrised UART: serial line in, decoded word,
// status flags and load-progress counters out.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 17
);
  logic                 rx;
  logic [DATA_BITS-1:0] data_out;
  logic                 valid;
  logic                 parity_err;
  logic                 frame_err;
  logic [CNT_W-1:0]     byte_count;
  logic                 programming_done;

  modport master (
    input  rx,
    output data_out, valid, parity_err, frame_err, byte_count, programming_done
  );

  modport slave (
    output rx,
    input  data_out, valid, parity_err, frame_err, byte_count, programming_done
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF synchroniser, mid-bit sampling, optional parity,
// 1-2 stop bits, break handling, saturating good-frame counter and load-done flag.
module uart_rx_param #(
  parameter int CLOCK_FREQ     = 100000000,
  parameter int BAUD_RATE      = 115200,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int EXPECTED_BYTES = 100000,
  parameter int CNT_W          = 17
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_rx_param_if.master bus
);
  localparam int BIT_TICKS = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF      = BIT_TICKS / 2;
  localparam int TW        = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam int BW        = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0]    TICK_FULL = TW'(BIT_TICKS - 1);
  localparam logic [TW-1:0]    TICK_HALF = TW'(HALF - 1);
  localparam logic [BW-1:0]    LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(EXPECTED_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_BRK
  } state_t;

  function automatic logic parity_err_f(input logic [DATA_BITS-1:0] d, input logic p);
    logic x;
    x = ^d ^ p;
    if (PARITY == 1)      return (x != 1'b1);
    else if (PARITY == 2) return (x != 1'b0);
    else                  return 1'b0;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  // Input synchroniser: rx_p0 -> rx_p1 (rx_s)
  logic rx_p0, rx_p1, rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= bus.rx;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s = rx_p1;

  state_t               state, state_n;
  logic [TW-1:0]        tick, tick_n;
  logic [BW-1:0]        bit_idx, bit_idx_n;
  logic                 stop_idx, stop_idx_n;
  logic                 fe_acc, fe_acc_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par_bit, par_bit_n;
  logic                 frame_end, frame_fe, frame_pe;

  // Frame FSM state and control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tick     <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      fe_acc   <= 1'b0;
    end else begin
      state    <= state_n;
      tick     <= tick_n;
      bit_idx  <= bit_idx_n;
      stop_idx <= stop_idx_n;
      fe_acc   <= fe_acc_n;
    end
  end

  // Received data bits carry no reset; they are only consumed at frame end
  always_ff @(posedge clk) begin
    shift   <= shift_n;
    par_bit <= par_bit_n;
  end

  always_comb begin
    state_n    = state;
    tick_n     = tick;
    bit_idx_n  = bit_idx;
    stop_idx_n = stop_idx;
    fe_acc_n   = fe_acc;
    shift_n    = shift;
    par_bit_n  = par_bit;
    frame_end  = 1'b0;
    frame_fe   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          tick_n  = TICK_HALF;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (tick != '0) begin
          tick_n = tick - 1'b1;
        end else if (rx_s) begin
          state_n = ST_IDLE;
        end else begin
          tick_n    = TICK_FULL;
          bit_idx_n = '0;
          state_n   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick != '0) begin
          tick_n = tick - 1'b1;
        end else begin
          shift_n = {rx_s, shift[DATA_BITS-1:1]};
          tick_n  = TICK_FULL;
          if (bit_idx == LAST_BIT) begin
            stop_idx_n = 1'b0;
            fe_acc_n   = 1'b0;
            state_n    = (PARITY != 0) ? ST_PAR : ST_STOP;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
          end
        end
      end
      ST_PAR: begin
        if (tick != '0) begin
          tick_n = tick - 1'b1;
        end else begin
          par_bit_n = rx_s;
          tick_n    = TICK_FULL;
          state_n   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick != '0) begin
          tick_n = tick - 1'b1;
        end else if (stop_idx == LAST_STOP) begin
          frame_end = 1'b1;
          frame_fe  = fe_acc | ~rx_s;
          // A low stop bit may be a break; hold off until the line idles
          state_n   = frame_fe ? ST_BRK : ST_IDLE;
        end else begin
          fe_acc_n   = fe_acc | ~rx_s;
          stop_idx_n = 1'b1;
          tick_n     = TICK_FULL;
        end
      end
      ST_BRK: begin
        if (rx_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign frame_pe = parity_err_f(shift, par_bit);

  // Output stage: registered on the final stop sample
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, pe_q, fe_q, done_q;
  logic [CNT_W-1:0]     cnt_q, cnt_inc;

  assign cnt_inc = sat_inc(cnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= frame_end;
      if (frame_end) begin
        data_q <= shift;
        pe_q   <= frame_pe;
        fe_q   <= frame_fe;
        if (!frame_pe && !frame_fe) begin
          cnt_q <= cnt_inc;
          if (cnt_inc == CNT_MAX) done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.data_out         = data_q;
  assign bus.valid            = valid_q;
  assign bus.parity_err       = pe_q;
  assign bus.frame_err        = fe_q;
  assign bus.byte_count       = cnt_q;
  assign bus.programming_done = done_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three configurations (8N1, 8E1, 7N2 with
// EXPECTED_BYTES = 3) at 16 clocks per bit.
module tb_uart_rx_param;
  logic clk   = 1'b0;
  logic rst_a = 1'b0;
  logic rst_bc = 1'b0;

  always #5 clk = ~clk;

  uart_rx_param_if #(.DATA_BITS(8), .CNT_W(17)) if_a ();
  uart_rx_param_if #(.DATA_BITS(8), .CNT_W(17)) if_b ();
  uart_rx_param_if #(.DATA_BITS(7), .CNT_W(2))  if_c ();

  uart_rx_param #(.CLOCK_FREQ(1600), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .EXPECTED_BYTES(100000), .CNT_W(17))
    dut_a (.clk(clk), .rst_n(rst_a), .bus(if_a));

  uart_rx_param #(.CLOCK_FREQ(1600), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .EXPECTED_BYTES(100000), .CNT_W(17))
    dut_b (.clk(clk), .rst_n(rst_bc), .bus(if_b));

  uart_rx_param #(.CLOCK_FREQ(1600), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(0),
                  .STOP_BITS(2), .EXPECTED_BYTES(3), .CNT_W(2))
    dut_c (.clk(clk), .rst_n(rst_bc), .bus(if_c));

  typedef struct {
    logic [8:0]  data;
    logic        pe;
    logic        fe;
    logic [31:0] cnt;
    logic        done;
  } rec_t;

  typedef struct {
    int unsigned sel;
    logic [8:0]  data;
    logic        par;
    logic        stop;
    logic [8:0]  e_data;
    logic        e_pe;
    logic        e_fe;
    logic [31:0] e_cnt;
    logic        e_done;
  } vec_t;

  rec_t q_a[$], q_b[$], q_c[$];
  int n_vec = 0;
  int n_miss = 0;

  initial begin
    if_a.rx = 1'b1;
    if_b.rx = 1'b1;
    if_c.rx = 1'b1;
  end

  // Each valid yields one record; counter and done are taken one cycle later
  initial forever begin
    rec_t r;
    @(negedge clk);
    if (if_a.valid) begin
      r.data = 9'(if_a.data_out); r.pe = if_a.parity_err; r.fe = if_a.frame_err;
      @(negedge clk);
      r.cnt = 32'(if_a.byte_count); r.done = if_a.programming_done;
      q_a.push_back(r);
    end
  end

  initial forever begin
    rec_t r;
    @(negedge clk);
    if (if_b.valid) begin
      r.data = 9'(if_b.data_out); r.pe = if_b.parity_err; r.fe = if_b.frame_err;
      @(negedge clk);
      r.cnt = 32'(if_b.byte_count); r.done = if_b.programming_done;
      q_b.push_back(r);
    end
  end

  initial forever begin
    rec_t r;
    @(negedge clk);
    if (if_c.valid) begin
      r.data = 9'(if_c.data_out); r.pe = if_c.parity_err; r.fe = if_c.frame_err;
      @(negedge clk);
      r.cnt = 32'(if_c.byte_count); r.done = if_c.programming_done;
      q_c.push_back(r);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_rx(input int unsigned sel, input logic v);
    case (sel)
      0: if_a.rx = v;
      1: if_b.rx = v;
      default: if_c.rx = v;
    endcase
  endtask

  task automatic bit_wait();
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input int unsigned sel, input logic [8:0] data,
                            input logic par, input logic stop_val);
    int nb;
    int ns;
    nb = (sel == 2) ? 7 : 8;
    ns = (sel == 2) ? 2 : 1;
    set_rx(sel, 1'b0);
    bit_wait();
    for (int i = 0; i < nb; i++) begin
      set_rx(sel, data[i]);
      bit_wait();
    end
    if (sel == 1) begin
      set_rx(sel, par);
      bit_wait();
    end
    for (int i = 0; i < ns; i++) begin
      set_rx(sel, stop_val);
      bit_wait();
    end
  endtask

  function automatic int qsize(input int unsigned sel);
    case (sel)
      0: return q_a.size();
      1: return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  task automatic get_rec(input int unsigned sel, output rec_t r);
    int waited;
    waited = 0;
    r = '{default: '1};
    while (qsize(sel) == 0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (qsize(sel) == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL valid_timeout: dut %0d gave no frame within %0d cycles", sel, waited);
    end else begin
      case (sel)
        0: r = q_a.pop_front();
        1: r = q_b.pop_front();
        default: r = q_c.pop_front();
      endcase
    end
  endtask

  task automatic expect_frame(input string tag, input int unsigned sel, input logic [8:0] d,
                              input logic pe, input logic fe, input logic [31:0] cnt,
                              input logic done);
    rec_t r;
    get_rec(sel, r);
    check({tag, "_data"}, 32'(r.data), 32'(d));
    check({tag, "_perr"}, 32'(r.pe), 32'(pe));
    check({tag, "_ferr"}, 32'(r.fe), 32'(fe));
    check({tag, "_count"}, r.cnt, cnt);
    check({tag, "_done"}, 32'(r.done), 32'(done));
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{0, 9'h0A5, 1'b0, 1'b1, 9'h0A5, 1'b0, 1'b0, 32'd1, 1'b0};
    vecs[1] = '{0, 9'h0FF, 1'b0, 1'b1, 9'h0FF, 1'b0, 1'b0, 32'd2, 1'b0};
    vecs[2] = '{1, 9'h007, 1'b0, 1'b1, 9'h007, 1'b1, 1'b0, 32'd0, 1'b0};
    vecs[3] = '{1, 9'h007, 1'b1, 1'b1, 9'h007, 1'b0, 1'b0, 32'd1, 1'b0};
    vecs[4] = '{1, 9'h081, 1'b1, 1'b1, 9'h081, 1'b1, 1'b0, 32'd1, 1'b0};
    vecs[5] = '{1, 9'h003, 1'b0, 1'b0, 9'h003, 1'b0, 1'b1, 32'd1, 1'b0};
    vecs[6] = '{2, 9'h011, 1'b0, 1'b1, 9'h011, 1'b0, 1'b0, 32'd1, 1'b0};
    vecs[7] = '{2, 9'h022, 1'b0, 1'b1, 9'h022, 1'b0, 1'b0, 32'd2, 1'b0};
    vecs[8] = '{2, 9'h033, 1'b0, 1'b1, 9'h033, 1'b0, 1'b0, 32'd3, 1'b1};
    vecs[9] = '{2, 9'h044, 1'b0, 1'b1, 9'h044, 1'b0, 1'b0, 32'd3, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_a_data",  32'(if_a.data_out), 32'h0);
    check("rst_a_valid", 32'(if_a.valid), 32'h0);
    check("rst_a_count", 32'(if_a.byte_count), 32'h0);
    check("rst_b_perr",  32'(if_b.parity_err), 32'h0);
    check("rst_c_done",  32'(if_c.programming_done), 32'h0);
    rst_a = 1'b1;
    rst_bc = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_a_valid", 32'(if_a.valid), 32'h0);
    check("idle_a_ferr",  32'(if_a.frame_err), 32'h0);

    for (int i = 0; i < 10; i++) begin
      send_frame(vecs[i].sel, vecs[i].data, vecs[i].par, vecs[i].stop);
      if (!vecs[i].stop) begin
        set_rx(vecs[i].sel, 1'b1);
        repeat (32) @(negedge clk);
      end
      expect_frame($sformatf("vec%0d", i), vecs[i].sel, vecs[i].e_data, vecs[i].e_pe,
                   vecs[i].e_fe, vecs[i].e_cnt, vecs[i].e_done);
    end
    check("c_extra_frames", 32'(q_c.size()), 32'h0);

    // Break: low stop bit then the line stays low for 40 bit times
    send_frame(0, 9'h0F0, 1'b0, 1'b0);
    expect_frame("brk", 0, 9'h0F0, 1'b0, 1'b1, 32'd2, 1'b0);
    repeat (40 * 16 - 16) @(negedge clk);
    check("brk_no_repeat", 32'(q_a.size()), 32'h0);
    check("brk_ferr_held", 32'(if_a.frame_err), 32'h1);
    set_rx(0, 1'b1);
    repeat (32) @(negedge clk);
    send_frame(0, 9'h03C, 1'b0, 1'b1);
    expect_frame("after_brk", 0, 9'h03C, 1'b0, 1'b0, 32'd3, 1'b0);

    // False start: a 5-cycle glitch is shorter than half a bit
    set_rx(0, 1'b0);
    repeat (5) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (48) @(negedge clk);
    check("false_start_no_valid", 32'(q_a.size()), 32'h0);
    send_frame(0, 9'h081, 1'b0, 1'b1);
    expect_frame("after_glitch", 0, 9'h081, 1'b0, 1'b0, 32'd4, 1'b0);

    // Reset in the middle of the data bits of 0x5A
    set_rx(0, 1'b0);
    bit_wait();
    set_rx(0, 1'b0); bit_wait();
    set_rx(0, 1'b1); bit_wait();
    set_rx(0, 1'b0); repeat (8) @(negedge clk);
    rst_a = 1'b0;
    #1;
    check("midrst_data",  32'(if_a.data_out), 32'h0);
    check("midrst_valid", 32'(if_a.valid), 32'h0);
    check("midrst_ferr",  32'(if_a.frame_err), 32'h0);
    check("midrst_count", 32'(if_a.byte_count), 32'h0);
    check("midrst_done",  32'(if_a.programming_done), 32'h0);
    set_rx(0, 1'b1);
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    repeat (300) @(negedge clk);
    check("midrst_no_valid", 32'(q_a.size()), 32'h0);
    send_frame(0, 9'h05A, 1'b0, 1'b1);
    expect_frame("after_rst", 0, 9'h05A, 1'b0, 1'b0, 32'd1, 1'b0);
    check("b_extra_frames", 32'(q_b.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
